// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int REQ_0 = 0;
    localparam int REQ_1 = 1;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: two request ports, shared read return.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] din1;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr0, addr1, din0, din1,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr0, addr1, din0, din1,
                    output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter_ram.sv
// Single-port synchronous RAM; read data appears the cycle after an enabled read.
module single_port_ram #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  en,
    input  logic                  we,
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else    dout      <= mem[addr];
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of one single-port RAM, one access per cycle.
// Define RAM_ARB_ROUND_ROBIN_EN for alternating priority; default is fixed priority to requester 0.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic              clk,
    input logic              rst,
    ram_port_arbiter_if.slave bus
);
    logic [1:0]            gnt;
    logic                  sel;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [1:0]            rvalid;
    logic                  favour1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic ptr, ptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= 1'b0;
        else     ptr <= ptr_nxt;
    end

    // Whoever was just granted loses priority to the other requester.
    always_comb begin
        ptr_nxt = ptr;
        if (gnt[REQ_0])      ptr_nxt = 1'b1;
        else if (gnt[REQ_1]) ptr_nxt = 1'b0;
    end

    assign favour1 = ptr;
`else
    assign favour1 = 1'b0;
`endif

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (bus.req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = favour1 ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign sel      = gnt[REQ_1];
    assign ram_en   = |gnt;
    assign ram_we   = ram_en & (sel ? bus.we[REQ_1] : bus.we[REQ_0]);
    assign ram_addr = sel ? bus.addr1 : bus.addr0;
    assign ram_din  = sel ? bus.din1  : bus.din0;

    single_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .en   (ram_en),
        .we   (ram_we),
        .clk  (clk),
        .din  (ram_din),
        .addr (ram_addr),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid <= 2'b00;
        else     rvalid <= gnt & ~bus.we;
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Vector table plus read-response scoreboard for ram_port_arbiter, in both arbitration modes.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_port_arbiter_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    ram_port_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] we;
        logic [2:0] a0, a1;
        logic [7:0] d0, d1;
        logic [1:0] g_rr;
        logic [1:0] g_fp;
    } vec_t;

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
    } rsp_t;

    vec_t vt[$];
    rsp_t sbq[$];
    logic [7:0] mdl [8];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] req, input logic [1:0] we,
                       input logic [2:0] a0, input logic [7:0] d0,
                       input logic [2:0] a1, input logic [7:0] d1,
                       input logic [1:0] g_rr, input logic [1:0] g_fp);
        vec_t v;
        v.rst = r; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.g_rr = g_rr; v.g_fp = g_fp;
        vt.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] req, input logic [1:0] we,
                         input logic [2:0] a0, input logic [7:0] d0,
                         input logic [2:0] a1, input logic [7:0] d1);
        rst = r; bus.req = req; bus.we = we;
        bus.addr0 = a0; bus.din0 = d0; bus.addr1 = a1; bus.din1 = d1;
    endtask

    initial begin
        vec_t v;
        rsp_t r;
        logic [1:0] eg;
        logic [2:0] a;
        logic       w;

        drive(1'b1, 2'b00, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00);

        //   rst  req    we     a0    d0     a1    d1     rr     fp
        add(1'b1, 2'b00, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 2'b00);
        add(1'b1, 2'b01, 2'b00, 3'd1, 8'h00, 3'd0, 8'h00, 2'b00, 2'b00);
        add(1'b0, 2'b01, 2'b01, 3'd3, 8'hA5, 3'd0, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b10, 2'b00, 3'd0, 8'h00, 3'd3, 8'h00, 2'b10, 2'b10);
        add(1'b0, 2'b01, 2'b01, 3'd1, 8'h11, 3'd0, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b10, 2'b10, 3'd0, 8'h00, 3'd2, 8'h22, 2'b10, 2'b10);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b10, 2'b01);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b10, 2'b01);
        add(1'b0, 2'b01, 2'b01, 3'd7, 8'hFF, 3'd0, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b10, 2'b00, 3'd0, 8'h00, 3'd7, 8'h00, 2'b10, 2'b10);
        add(1'b0, 2'b00, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 2'b00);
        add(1'b0, 2'b11, 2'b01, 3'd5, 8'h3C, 3'd2, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b01, 2'b00, 3'd5, 8'h00, 3'd0, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b10, 2'b01);
        add(1'b1, 2'b01, 2'b00, 3'd1, 8'h00, 3'd0, 8'h00, 2'b00, 2'b00);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b01, 2'b01);
        add(1'b0, 2'b11, 2'b00, 3'd1, 8'h00, 3'd2, 8'h00, 2'b10, 2'b01);
        add(1'b0, 2'b00, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 2'b00);
        add(1'b0, 2'b00, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 2'b00);

        foreach (vt[i]) begin
            v = vt[i];
`ifdef RAM_ARB_ROUND_ROBIN_EN
            eg = v.g_rr;
`else
            eg = v.g_fp;
`endif
            @(posedge clk); #1;
            drive(v.rst, v.req, v.we, v.a0, v.d0, v.a1, v.d1);
            @(negedge clk);

            // Responses due now come from last cycle's grants; reset discards them.
            if (v.rst) begin
                check("rvalid_in_reset", {30'd0, bus.rvalid}, 32'd0);
                sbq.delete();
            end else if (sbq.size() > 0) begin
                r = sbq.pop_front();
                check("rvalid", {30'd0, bus.rvalid}, {30'd0, r.who});
                check("rdata", {24'd0, bus.rdata}, {24'd0, r.data});
            end else begin
                check("rvalid_idle", {30'd0, bus.rvalid}, 32'd0);
            end

            check("gnt", {30'd0, bus.gnt}, {30'd0, eg});
            check("ram_en", {31'd0, dut.ram_en}, {31'd0, |eg});

            if (eg != 2'b00) begin
                w = eg[1] ? v.we[1] : v.we[0];
                a = eg[1] ? v.a1 : v.a0;
                if (w) begin
                    mdl[a] = eg[1] ? v.d1 : v.d0;
                end else begin
                    r.who = eg; r.data = mdl[a];
                    sbq.push_back(r);
                end
            end
        end

        // Asynchronous reset landing while a read response is on the bus.
        @(posedge clk); #1;
        drive(1'b0, 2'b01, 2'b00, 3'd1, 8'h00, 3'd0, 8'h00);
        @(negedge clk);
        check("seq_gnt_read", {30'd0, bus.gnt}, 32'd1);
        @(posedge clk); #2;
        check("seq_rvalid_pre_rst", {30'd0, bus.rvalid}, 32'd1);
        check("seq_rdata_pre_rst", {24'd0, bus.rdata}, 32'h11);
        rst = 1'b1;
        #1;
        check("seq_rvalid_async_rst", {30'd0, bus.rvalid}, 32'd0);
        check("seq_gnt_async_rst", {30'd0, bus.gnt}, 32'd0);
        check("seq_en_async_rst", {31'd0, dut.ram_en}, 32'd0);
        @(negedge clk);
        check("seq_rvalid_rst_hold", {30'd0, bus.rvalid}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 2'b11, 2'b00, 3'd7, 8'h00, 3'd2, 8'h00);
        @(negedge clk);
        check("seq_gnt_after_rst", {30'd0, bus.gnt}, 32'd1);
        check("seq_rvalid_after_rst", {30'd0, bus.rvalid}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00);
        @(negedge clk);
        check("seq_rvalid_top_addr", {30'd0, bus.rvalid}, 32'd1);
        check("seq_rdata_top_addr", {24'd0, bus.rdata}, 32'hFF);
        check("seq_gnt_idle", {30'd0, bus.gnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
